// File: rtl/demo_dual_scheduler.sv
// Round-robin scheduler for the A/B demo pair that share one UART cross-link.
// Optional per-transaction watchdog enabled by defining SCHED_TIMEOUT_EN.
module demo_dual_scheduler #(
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int TO_WIDTH       = 24,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_a,
  input  logic                 req_b,
  input  logic                 mode_req_a,
  input  logic                 mode_req_b,
  input  logic                 ready_a,
  input  logic                 ready_b,
  output logic                 start_a,
  output logic                 start_b,
  output logic                 mode_a,
  output logic                 mode_b,
  output logic                 grant_a,
  output logic                 grant_b,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] done_cnt_a,
  output logic [CNT_WIDTH-1:0] done_cnt_b,
  output logic                 timeout_a,
  output logic                 timeout_b
);

  typedef enum logic [1:0] {IDLE, START, RUN, GAP} state_t;

  localparam logic [TO_WIDTH-1:0] GAP_LAST = TO_WIDTH'(GAP_CYCLES - 1);
`ifdef SCHED_TIMEOUT_EN
  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);
`else
  localparam logic [TO_WIDTH-1:0] unused_timeout = TO_WIDTH'(TIMEOUT_CYCLES);
`endif

  state_t              state, state_nxt;
  logic                side, side_nxt;   // owner of the current transaction: 0 = A, 1 = B
  logic                ptr, ptr_nxt;     // side to favour when both are pending
  logic [TO_WIDTH-1:0] cnt, cnt_nxt;
  logic                req_a_q, req_b_q, pend_a, pend_b;
  logic                take_a, take_b, done_inc, to_set;
  logic                ready_sel;

  assign ready_sel = side ? ready_b : ready_a;

  // NOTE: every combinational output gets a default first, so no path leaves a latch.
  always_comb begin
    state_nxt = state;
    side_nxt  = side;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    take_a    = 1'b0;
    take_b    = 1'b0;
    done_inc  = 1'b0;
    to_set    = 1'b0;
    case (state)
      IDLE: begin
        if (ready_a && ready_b && (pend_a || pend_b)) begin
          if (pend_a && pend_b) begin
            side_nxt = ptr;
            ptr_nxt  = ~ptr;
          end else begin
            side_nxt = pend_b;
            ptr_nxt  = ~pend_b;
          end
          take_a    = ~side_nxt;
          take_b    = side_nxt;
          cnt_nxt   = '0;
          state_nxt = START;
        end
      end
      START: if (!ready_sel) state_nxt = RUN;
      RUN: begin
        if (ready_sel) begin
          done_inc  = 1'b1;
          cnt_nxt   = '0;
          state_nxt = GAP;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) state_nxt = IDLE;
        else                 cnt_nxt   = cnt + 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
`ifdef SCHED_TIMEOUT_EN
    // The watchdog wins over a completion seen on the same edge.
    if (state == START || state == RUN) begin
      if (cnt == TO_LAST) begin
        to_set    = 1'b1;
        done_inc  = 1'b0;
        cnt_nxt   = '0;
        state_nxt = GAP;
      end else if (state_nxt != GAP) begin
        cnt_nxt = cnt + 1'b1;
      end
    end
`endif
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      side       <= 1'b0;
      ptr        <= 1'b0;
      cnt        <= '0;
      req_a_q    <= 1'b0;
      req_b_q    <= 1'b0;
      pend_a     <= 1'b0;
      pend_b     <= 1'b0;
      mode_a     <= 1'b0;
      mode_b     <= 1'b0;
      done_cnt_a <= '0;
      done_cnt_b <= '0;
    end else begin
      state   <= state_nxt;
      side    <= side_nxt;
      ptr     <= ptr_nxt;
      cnt     <= cnt_nxt;
      req_a_q <= req_a;
      req_b_q <= req_b;
      // A fresh edge on the grant cycle keeps the request pending.
      pend_a  <= (req_a & ~req_a_q) | (pend_a & ~take_a);
      pend_b  <= (req_b & ~req_b_q) | (pend_b & ~take_b);
      if (take_a) mode_a <= mode_req_a;
      if (take_b) mode_b <= mode_req_b;
      if (done_inc && !side) done_cnt_a <= done_cnt_a + CNT_WIDTH'(1);
      if (done_inc &&  side) done_cnt_b <= done_cnt_b + CNT_WIDTH'(1);
    end
  end

`ifdef SCHED_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_a <= 1'b0;
      timeout_b <= 1'b0;
    end else begin
      if (to_set && !side) timeout_a <= 1'b1;
      if (to_set &&  side) timeout_b <= 1'b1;
    end
  end
`else
  logic unused_to_set;
  assign unused_to_set = to_set;
  assign timeout_a     = 1'b0;
  assign timeout_b     = 1'b0;
`endif

  assign start_a = (state == START) && !side;
  assign start_b = (state == START) &&  side;
  assign grant_a = (state == START || state == RUN) && !side;
  assign grant_b = (state == START || state == RUN) &&  side;
  assign busy    = (state != IDLE);

endmodule
